// File: rtl/cache_pkg.sv
// Shared encodings for the cache cell controller.
//   op_e    : command opcodes carried on cmd_op
//   st_e    : response status codes carried on resp_status
//   state_e : controller FSM states
package cache_pkg;

    typedef enum logic [1:0] {
        OP_RSVD = 2'b00,
        OP_GET  = 2'b01,
        OP_SET  = 2'b10,
        OP_DEL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_MISS = 2'b01,
        ST_FULL = 2'b10,
        ST_ERR  = 2'b11
    } st_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SCAN  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/cell_onehot_decoder.sv
// Index to one-hot decoder with enable.
//   idx    : binary cell index
//   en     : when low, all outputs are zero
//   onehot : NUM_CELLS-wide one-hot select
module cell_onehot_decoder #(
    parameter int NUM_CELLS = 8,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic [IDX_W-1:0]     idx,
    input  logic                 en,
    output logic [NUM_CELLS-1:0] onehot
);

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_bit
        assign onehot[i] = en && (idx == IDX_W'(i));
    end

endmodule

// File: rtl/cache_cell_controller.sv
// Command-side controller for the memory cell array.
//   cmd_*      : GET/SET/DEL request channel (valid/ready)
//   cell_read  : one-hot read select, one cell per SCAN cycle
//   cell_write : one-hot write strobe, one cycle in WRITE
//   wr_*       : latched command fields, held for the whole transaction
//   rd_key/rd_value : combinational readback of the selected cell
//   resp_*     : status/value response channel (valid/ready)
//   occupied   : per-cell valid bits owned by this block
module cache_cell_controller
    import cache_pkg::*;
#(
    parameter int NUM_CELLS   = 8,
    parameter int KEY_WIDTH   = 8,
    parameter int VALUE_WIDTH = 64,
    parameter int TTL_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [KEY_WIDTH-1:0]   cmd_key,
    input  logic [VALUE_WIDTH-1:0] cmd_value,
    input  logic [TTL_WIDTH-1:0]   cmd_ttl,
    output logic [NUM_CELLS-1:0]   cell_read,
    output logic [NUM_CELLS-1:0]   cell_write,
    output logic [KEY_WIDTH-1:0]   wr_key,
    output logic [VALUE_WIDTH-1:0] wr_value,
    output logic [TTL_WIDTH-1:0]   wr_ttl,
    input  logic [KEY_WIDTH-1:0]   rd_key,
    input  logic [VALUE_WIDTH-1:0] rd_value,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [1:0]             resp_status,
    output logic [VALUE_WIDTH-1:0] resp_value,
    output logic [NUM_CELLS-1:0]   occupied
);

    localparam int IDX_W = $clog2(NUM_CELLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

    state_e           state, nxt;
    op_e              op_q;
    logic [IDX_W-1:0] idx, free_idx, target;
    logic             free_found;
    logic             rd_en, wr_en;

    logic accept, hit, last, free_avail;
    logic [IDX_W-1:0] free_sel;

    assign accept     = cmd_valid && cmd_ready;
    assign hit        = occupied[idx] && (rd_key == wr_key);
    assign last       = (idx == LAST_IDX);
    // The cell under scan counts as free if nothing lower was free.
    assign free_avail = free_found || !occupied[idx];
    assign free_sel   = free_found ? free_idx : idx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (accept) nxt = (cmd_op == OP_RSVD) ? RESP : SCAN;
            SCAN: begin
                if (hit)       nxt = (op_q == OP_SET) ? WRITE : RESP;
                else if (last) nxt = (op_q == OP_SET && free_avail) ? WRITE : RESP;
            end
            WRITE: nxt = RESP;
            RESP:  if (resp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        rd_en      = (state == SCAN);
        wr_en      = (state == WRITE);
    end

    cell_onehot_decoder #(.NUM_CELLS(NUM_CELLS), .IDX_W(IDX_W)) u_rd_dec (
        .idx(idx), .en(rd_en), .onehot(cell_read)
    );

    cell_onehot_decoder #(.NUM_CELLS(NUM_CELLS), .IDX_W(IDX_W)) u_wr_dec (
        .idx(target), .en(wr_en), .onehot(cell_write)
    );

    // Datapath: latched command, scan bookkeeping, occupancy, response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_RSVD;
            wr_key      <= '0;
            wr_value    <= '0;
            wr_ttl      <= '0;
            idx         <= '0;
            free_idx    <= '0;
            free_found  <= 1'b0;
            target      <= '0;
            occupied    <= '0;
            resp_status <= ST_OK;
            resp_value  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q       <= op_e'(cmd_op);
                    wr_key     <= cmd_key;
                    wr_value   <= cmd_value;
                    wr_ttl     <= cmd_ttl;
                    idx        <= '0;
                    free_found <= 1'b0;
                    resp_value <= '0;
                    resp_status <= (cmd_op == OP_RSVD) ? ST_ERR : ST_OK;
                end
                SCAN: begin
                    if (hit) begin
                        case (op_q)
                            OP_GET: begin
                                resp_value  <= rd_value;
                                resp_status <= ST_OK;
                            end
                            OP_SET: target <= idx;
                            OP_DEL: begin
                                occupied[idx] <= 1'b0;
                                resp_status   <= ST_OK;
                            end
                            default: resp_status <= ST_ERR;
                        endcase
                    end else begin
                        if (!occupied[idx] && !free_found) begin
                            free_found <= 1'b1;
                            free_idx   <= idx;
                        end
                        if (!last) begin
                            idx <= idx + 1'b1;
                        end else if (op_q == OP_SET) begin
                            if (free_avail) target <= free_sel;
                            else            resp_status <= ST_FULL;
                        end else begin
                            resp_status <= ST_MISS;
                        end
                    end
                end
                WRITE: begin
                    occupied[target] <= 1'b1;
                    resp_status      <= ST_OK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_cell_controller.sv
module tb_cache_cell_controller;

    localparam int N  = 8;
    localparam int KW = 8;
    localparam int VW = 64;
    localparam int TW = 32;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          cmd_valid = 0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 0;
    logic [KW-1:0] cmd_key = 0;
    logic [VW-1:0] cmd_value = 0;
    logic [TW-1:0] cmd_ttl = 0;
    logic [N-1:0]  cell_read, cell_write;
    logic [KW-1:0] wr_key;
    logic [VW-1:0] wr_value;
    logic [TW-1:0] wr_ttl;
    logic [KW-1:0] rd_key;
    logic [VW-1:0] rd_value;
    logic          resp_valid;
    logic          resp_ready = 0;
    logic [1:0]    resp_status;
    logic [VW-1:0] resp_value;
    logic [N-1:0]  occupied;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_cell_controller #(.NUM_CELLS(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TTL_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .cmd_value(cmd_value), .cmd_ttl(cmd_ttl),
        .cell_read(cell_read), .cell_write(cell_write),
        .wr_key(wr_key), .wr_value(wr_value), .wr_ttl(wr_ttl),
        .rd_key(rd_key), .rd_value(rd_value),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_value(resp_value),
        .occupied(occupied)
    );

    // Behavioural cell array: stores on strobe, OR-combines selected cells.
    logic [KW-1:0] mem_key [N];
    logic [VW-1:0] mem_val [N];
    logic [TW-1:0] mem_ttl [N];

    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (cell_write[i]) begin
                mem_key[i] <= wr_key;
                mem_val[i] <= wr_value;
                mem_ttl[i] <= wr_ttl;
            end

    always_comb begin
        rd_key   = '0;
        rd_value = '0;
        for (int i = 0; i < N; i++)
            if (cell_read[i]) begin
                rd_key   = rd_key | mem_key[i];
                rd_value = rd_value | mem_val[i];
            end
    end

    logic overlap_seen = 0;
    always @(negedge clk)
        if ((cell_read & cell_write) != '0) overlap_seen <= 1'b1;

    // Issues one command, then observes until the response is consumed.
    // lat/wcyc are cycles after the accept edge (T+n); -1 if never seen.
    task automatic run_cmd(input logic [1:0] op, input logic [KW-1:0] key,
                           input logic [VW-1:0] val, input logic [TW-1:0] ttl,
                           output int lat, output logic [1:0] st, output logic [VW-1:0] rv,
                           output int wcyc, output logic [N-1:0] wmask,
                           output logic [N-1:0] rfirst);
        lat = -1; wcyc = -1; wmask = '0; st = 'x; rv = 'x; rfirst = '0;
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_key = key; cmd_value = val; cmd_ttl = ttl;
        @(posedge clk);
        #1 cmd_valid = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) rfirst = cell_read;
            if (cell_write != '0 && wcyc < 0) begin
                wcyc = n; wmask = cell_write;
            end
            if (resp_valid) begin
                lat = n; st = resp_status; rv = resp_value;
                resp_ready = 1;
                @(posedge clk);
                #1 resp_ready = 0;
                break;
            end
        end
    endtask

    int lat, wcyc;
    logic [1:0] st;
    logic [VW-1:0] rv;
    logic [N-1:0] wm, rf;

    task automatic test_reset();
        rst_n = 0;
        #12;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if ({cell_read, cell_write, occupied} !== '0) begin failures++; $display("FAIL reset_cells got=%h exp=0", {cell_read, cell_write, occupied}); end
        checks++; if ({resp_status, resp_value, wr_key, wr_value, wr_ttl} !== '0) begin failures++; $display("FAIL reset_regs got=%h exp=0", {resp_status, resp_value, wr_key, wr_value, wr_ttl}); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_set_empty();
        run_cmd(2'b10, 8'h11, 64'hDEADBEEF, 32'd100, lat, st, rv, wcyc, wm, rf);
        checks++; if (wcyc !== 9 || wm !== 8'h01) begin failures++; $display("FAIL set_empty_write got=cyc%0d/%h exp=cyc9/01", wcyc, wm); end
        checks++; if (lat !== 10 || st !== 2'b00 || rv !== '0) begin failures++; $display("FAIL set_empty_resp got=%0d/%b/%h exp=10/00/0", lat, st, rv); end
        checks++; if (occupied !== 8'h01) begin failures++; $display("FAIL set_empty_occ got=%h exp=01", occupied); end
        checks++; if (mem_key[0] !== 8'h11 || mem_ttl[0] !== 32'd100) begin failures++; $display("FAIL set_empty_cell got=%h/%0d exp=11/100", mem_key[0], mem_ttl[0]); end
    endtask

    task automatic test_get();
        run_cmd(2'b01, 8'h11, 64'h0, 32'h0, lat, st, rv, wcyc, wm, rf);
        checks++; if (rf !== 8'h01) begin failures++; $display("FAIL get_hit_read got=%h exp=01", rf); end
        checks++; if (lat !== 2 || st !== 2'b00 || rv !== 64'hDEADBEEF || wcyc !== -1) begin failures++; $display("FAIL get_hit got=%0d/%b/%h/w%0d exp=2/00/deadbeef/w-1", lat, st, rv, wcyc); end
        run_cmd(2'b01, 8'h22, 64'h0, 32'h0, lat, st, rv, wcyc, wm, rf);
        checks++; if (lat !== 9 || st !== 2'b01 || rv !== '0) begin failures++; $display("FAIL get_miss got=%0d/%b/%h exp=9/01/0", lat, st, rv); end
    endtask

    task automatic test_overwrite();
        run_cmd(2'b10, 8'h11, 64'h5, 32'd7, lat, st, rv, wcyc, wm, rf);
        checks++; if (wcyc !== 2 || wm !== 8'h01 || lat !== 3 || st !== 2'b00) begin failures++; $display("FAIL overwrite got=w%0d/%h/%0d/%b exp=w2/01/3/00", wcyc, wm, lat, st); end
        checks++; if (occupied !== 8'h01) begin failures++; $display("FAIL overwrite_occ got=%h exp=01", occupied); end
        run_cmd(2'b01, 8'h11, 64'h0, 32'h0, lat, st, rv, wcyc, wm, rf);
        checks++; if (rv !== 64'h5 || st !== 2'b00) begin failures++; $display("FAIL overwrite_get got=%h/%b exp=5/00", rv, st); end
    endtask

    task automatic test_full_del();
        logic [KW-1:0] k;
        int bad = 0;
        for (int i = 1; i < N; i++) begin
            k = 8'h20 + KW'(i);
            run_cmd(2'b10, k, 64'h100 + VW'(i), 32'h0, lat, st, rv, wcyc, wm, rf);
            if (wcyc !== 9 || wm !== (8'h01 << i) || st !== 2'b00) bad++;
        end
        checks++; if (bad !== 0 || occupied !== 8'hFF) begin failures++; $display("FAIL fill got=bad%0d/%h exp=bad0/ff", bad, occupied); end
        run_cmd(2'b10, 8'h99, 64'h99, 32'h0, lat, st, rv, wcyc, wm, rf);
        checks++; if (st !== 2'b10 || lat !== 9 || wcyc !== -1) begin failures++; $display("FAIL full got=%b/%0d/w%0d exp=10/9/w-1", st, lat, wcyc); end
        run_cmd(2'b11, 8'h23, 64'h0, 32'h0, lat, st, rv, wcyc, wm, rf);
        checks++; if (st !== 2'b00 || lat !== 5 || occupied !== 8'hF7) begin failures++; $display("FAIL del got=%b/%0d/%h exp=00/5/f7", st, lat, occupied); end
        run_cmd(2'b10, 8'h99, 64'h99, 32'h0, lat, st, rv, wcyc, wm, rf);
        checks++; if (wm !== 8'h08 || wcyc !== 9 || lat !== 10 || occupied !== 8'hFF) begin failures++; $display("FAIL set_reuse got=%h/w%0d/%0d/%h exp=08/w9/10/ff", wm, wcyc, lat, occupied); end
        run_cmd(2'b01, 8'h99, 64'h0, 32'h0, lat, st, rv, wcyc, wm, rf);
        checks++; if (lat !== 5 || rv !== 64'h99) begin failures++; $display("FAIL get_reuse got=%0d/%h exp=5/99", lat, rv); end
        // Only the last cell free: it must be chosen.
        run_cmd(2'b11, 8'h27, 64'h0, 32'h0, lat, st, rv, wcyc, wm, rf);
        checks++; if (lat !== 9 || occupied !== 8'h7F) begin failures++; $display("FAIL del_last got=%0d/%h exp=9/7f", lat, occupied); end
        run_cmd(2'b10, 8'hAA, 64'hAA, 32'h0, lat, st, rv, wcyc, wm, rf);
        checks++; if (wm !== 8'h80 || wcyc !== 9 || st !== 2'b00) begin failures++; $display("FAIL set_last got=%h/w%0d/%b exp=80/w9/00", wm, wcyc, st); end
        run_cmd(2'b11, 8'h55, 64'h0, 32'h0, lat, st, rv, wcyc, wm, rf);
        checks++; if (st !== 2'b01 || lat !== 9) begin failures++; $display("FAIL del_miss got=%b/%0d exp=01/9", st, lat); end
    endtask

    task automatic test_err_hold();
        int bad = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_op = 2'b00; cmd_key = 8'h11;
        @(posedge clk);
        #1 cmd_valid = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (!resp_valid || resp_status !== 2'b11 || resp_value !== '0 || cmd_ready !== 1'b0 ||
                cell_read !== '0 || cell_write !== '0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL err_hold got=bad%0d exp=bad0", bad); end
        resp_ready = 1;
        @(posedge clk);
        #1 resp_ready = 0;
        checks++; if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL err_release got=%b/%b exp=0/1", resp_valid, cmd_ready); end
    endtask

    task automatic test_reset_mid_scan();
        int wr = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_op = 2'b10; cmd_key = 8'h66; cmd_value = 64'h66;
        @(posedge clk);
        #1 cmd_valid = 0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        checks++; if ({cell_read, cell_write, occupied, resp_valid} !== '0 || cmd_ready !== 1'b1 || wr_key !== '0) begin failures++; $display("FAIL mid_reset got=%h/%b/%h exp=0/1/0", {cell_read, cell_write, occupied, resp_valid}, cmd_ready, wr_key); end
        @(negedge clk);
        rst_n = 1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (cell_write !== '0 || resp_valid !== 1'b0) wr++;
        end
        checks++; if (wr !== 0 || occupied !== '0) begin failures++; $display("FAIL post_reset got=%0d/%h exp=0/0", wr, occupied); end
    endtask

    initial begin
        test_reset();
        test_set_empty();
        test_get();
        test_overwrite();
        test_full_del();
        test_err_hold();
        test_reset_mid_scan();
        checks++; if (overlap_seen !== 1'b0) begin failures++; $display("FAIL rd_wr_overlap got=%b exp=0", overlap_seen); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
